// File: rtl/water_level_if.sv
// Probe, display and pump signals between the tank pins and the level controller.
interface water_level_if #(
  parameter int NUM_LEVELS = 5,
  parameter int LW         = $clog2(NUM_LEVELS + 1)
);
  logic [NUM_LEVELS-1:0] sensor;
  logic [NUM_LEVELS-1:0] led;
  logic [LW-1:0]         level;
  logic                  alarm_low;
  logic                  alarm_high;
  logic                  fault;
  logic                  pump_on;

  modport master (
    output sensor,
    input  led, level, alarm_low, alarm_high, fault, pump_on
  );

  modport slave (
    input  sensor,
    output led, level, alarm_low, alarm_high, fault, pump_on
  );
endinterface

// File: rtl/water_level_ctrl.sv
// Tank level monitor: synchronise and debounce probes, decode level/alarms/fault,
// and drive the pump through a hysteretic FSM.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | pump off, waiting for level to fall to LOW_THR
// ST_FILL  | pump on until level reaches HIGH_THR
// ST_FAULT | probes inconsistent, pump held off
module water_level_ctrl #(
  parameter int NUM_LEVELS      = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOW_THR         = 1,
  parameter int HIGH_THR        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  water_level_if.slave  bus
);
  localparam int LW = $clog2(NUM_LEVELS + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOW_L    = LW'(LOW_THR);
  localparam logic [LW-1:0] HIGH_L   = LW'(HIGH_THR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  logic [NUM_LEVELS-1:0] s1, s2, filt;
  logic [CW-1:0]         cnt [NUM_LEVELS];

  logic [NUM_LEVELS-1:0] led_d, led_q;
  logic [LW-1:0]         level_d, level_q;
  logic                  fault_d, fault_q;
  logic                  alarm_low_q, alarm_high_q;

  state_t state_q, state_d;
  logic   pump_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      filt <= '0;
      for (int i = 0; i < NUM_LEVELS; i++) cnt[i] <= '0;
    end else begin
      s1 <= bus.sensor;
      s2 <= s1;
      // filt flips on the edge the mismatch count would reach DEBOUNCE_CYCLES
      for (int i = 0; i < NUM_LEVELS; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          filt[i] <= ~filt[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic acc;
    logic dry_below;
    level_d   = '0;
    led_d     = '0;
    fault_d   = 1'b0;
    acc       = 1'b0;
    dry_below = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (filt[i]) level_d = LW'(i + 1);
      if (filt[i] && dry_below) fault_d = 1'b1;
      dry_below = dry_below | ~filt[i];
    end
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      acc      = acc | filt[i];
      led_d[i] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q        <= '0;
      level_q      <= '0;
      fault_q      <= 1'b0;
      alarm_low_q  <= 1'b1;
      alarm_high_q <= 1'b0;
    end else begin
      led_q        <= led_d;
      level_q      <= level_d;
      fault_q      <= fault_d;
      alarm_low_q  <= (level_d <= LOW_L);
      alarm_high_q <= (level_d >= HIGH_L);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fault_q)                 state_d = ST_FAULT;
        else if (level_q <= LOW_L)   state_d = ST_FILL;
      end
      ST_FILL: begin
        if (fault_q)                 state_d = ST_FAULT;
        else if (level_q >= HIGH_L)  state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!fault_q)                state_d = ST_IDLE;
      end
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pump_q  <= (state_d == ST_FILL);
    end
  end

  assign bus.led        = led_q;
  assign bus.level      = level_q;
  assign bus.alarm_low  = alarm_low_q;
  assign bus.alarm_high = alarm_high_q;
  assign bus.fault      = fault_q;
  assign bus.pump_on    = pump_q;
endmodule
